// File: rtl/ex_mem_flag_stage.sv
// EX/MEM pipeline register with the architectural NZCV flag register and
// same-cycle resolution of B.cond, CBZ and CBNZ.
module ex_mem_flag_stage #(
    parameter int WIDTH = 64,
    parameter int REGW  = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ex_valid,
    input  logic [WIDTH-1:0] ex_result,
    input  logic             ex_negative,
    input  logic             ex_zero,
    input  logic             ex_overflow,
    input  logic             ex_carry_out,
    input  logic             ex_set_flags,
    input  logic             ex_logic_op,
    input  logic             ex_is_bcond,
    input  logic [3:0]       ex_cond,
    input  logic             ex_is_cbz,
    input  logic             ex_is_cbnz,
    input  logic [WIDTH-1:0] ex_store_data,
    input  logic [REGW-1:0]  ex_rd,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic             ex_mem_write,
    input  logic             stall,
    input  logic             flush,
    output logic             ex_branch_taken,
    output logic             mem_valid,
    output logic             mem_reg_write,
    output logic             mem_mem_read,
    output logic             mem_mem_write,
    output logic [WIDTH-1:0] mem_result,
    output logic [WIDTH-1:0] mem_store_data,
    output logic [REGW-1:0]  mem_rd,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_v,
    output logic             flag_c
);

    logic commit;
    logic cond_true;

    assign commit = ex_valid & ~stall & ~flush;

    // B.cond reads the committed flags; the prior setter already wrote them
    always_comb begin
        cond_true = 1'b0;
        case (ex_cond)
            4'b0000: cond_true = flag_z;
            4'b0001: cond_true = ~flag_z;
            4'b0010: cond_true = flag_c;
            4'b0011: cond_true = ~flag_c;
            4'b0100: cond_true = flag_n;
            4'b0101: cond_true = ~flag_n;
            4'b0110: cond_true = flag_v;
            4'b0111: cond_true = ~flag_v;
            4'b1000: cond_true = flag_c & ~flag_z;
            4'b1001: cond_true = ~flag_c | flag_z;
            4'b1010: cond_true = (flag_n == flag_v);
            4'b1011: cond_true = (flag_n != flag_v);
            4'b1100: cond_true = ~flag_z & (flag_n == flag_v);
            4'b1101: cond_true = flag_z | (flag_n != flag_v);
            default: cond_true = 1'b1;
        endcase
    end

    assign ex_branch_taken = reset_n & commit &
                             ((ex_is_bcond & cond_true) |
                              (ex_is_cbz   & ex_zero)   |
                              (ex_is_cbnz  & ~ex_zero));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_valid      <= 1'b0;
            mem_reg_write  <= 1'b0;
            mem_mem_read   <= 1'b0;
            mem_mem_write  <= 1'b0;
            mem_result     <= '0;
            mem_store_data <= '0;
            mem_rd         <= '0;
        end else if (flush) begin
            mem_valid      <= 1'b0;
            mem_reg_write  <= 1'b0;
            mem_mem_read   <= 1'b0;
            mem_mem_write  <= 1'b0;
        end else if (!stall) begin
            mem_valid      <= ex_valid;
            mem_reg_write  <= ex_valid & ex_reg_write;
            mem_mem_read   <= ex_valid & ex_mem_read;
            mem_mem_write  <= ex_valid & ex_mem_write;
            mem_result     <= ex_result;
            mem_store_data <= ex_store_data;
            mem_rd         <= ex_rd;
        end
    end

    // Logic ops leave V and C architecturally cleared
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flag_n <= 1'b0;
            flag_z <= 1'b0;
            flag_v <= 1'b0;
            flag_c <= 1'b0;
        end else if (commit && ex_set_flags) begin
            flag_n <= ex_negative;
            flag_z <= ex_zero;
            flag_v <= ex_logic_op ? 1'b0 : ex_overflow;
            flag_c <= ex_logic_op ? 1'b0 : ex_carry_out;
        end
    end

endmodule

// File: tb/tb_ex_mem_flag_stage.sv
// Directed and randomized bench for ex_mem_flag_stage; random B.cond
// expectations come from comparing the SUBS operands directly.
module tb_ex_mem_flag_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ex_valid, ex_negative, ex_zero, ex_overflow, ex_carry_out;
    logic        ex_set_flags, ex_logic_op, ex_is_bcond, ex_is_cbz, ex_is_cbnz;
    logic [3:0]  ex_cond;
    logic [63:0] ex_result, ex_store_data;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, stall, flush;
    logic        ex_branch_taken;
    logic        mem_valid, mem_reg_write, mem_mem_read, mem_mem_write;
    logic [63:0] mem_result, mem_store_data;
    logic [4:0]  mem_rd;
    logic        flag_n, flag_z, flag_v, flag_c;

    int passes = 0;
    int total  = 0;

    // reference state
    logic        m_valid, m_rw, m_mr, m_mw;
    logic [63:0] m_result, m_sdata;
    logic [4:0]  m_rd;
    logic [3:0]  m_nzcv;

    ex_mem_flag_stage #(.WIDTH(64), .REGW(5)) dut (
        .clk(clk), .reset_n(reset_n), .ex_valid(ex_valid), .ex_result(ex_result),
        .ex_negative(ex_negative), .ex_zero(ex_zero), .ex_overflow(ex_overflow),
        .ex_carry_out(ex_carry_out), .ex_set_flags(ex_set_flags),
        .ex_logic_op(ex_logic_op), .ex_is_bcond(ex_is_bcond), .ex_cond(ex_cond),
        .ex_is_cbz(ex_is_cbz), .ex_is_cbnz(ex_is_cbnz), .ex_store_data(ex_store_data),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .stall(stall), .flush(flush),
        .ex_branch_taken(ex_branch_taken), .mem_valid(mem_valid),
        .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
        .mem_mem_write(mem_mem_write), .mem_result(mem_result),
        .mem_store_data(mem_store_data), .mem_rd(mem_rd),
        .flag_n(flag_n), .flag_z(flag_z), .flag_v(flag_v), .flag_c(flag_c)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic idle();
        ex_valid = 0; ex_result = '0; ex_negative = 0; ex_zero = 0; ex_overflow = 0;
        ex_carry_out = 0; ex_set_flags = 0; ex_logic_op = 0; ex_is_bcond = 0;
        ex_cond = 4'd0; ex_is_cbz = 0; ex_is_cbnz = 0; ex_store_data = '0; ex_rd = '0;
        ex_reg_write = 0; ex_mem_read = 0; ex_mem_write = 0; stall = 0; flush = 0;
    endtask

    function automatic logic [3:0] nzcv();
        return {flag_n, flag_z, flag_c, flag_v};
    endfunction

    // advance one edge; the model follows the behavioural rules, then all
    // registered outputs are compared
    task automatic tick(input string tag);
        logic commit;
        commit = ex_valid & ~stall & ~flush;
        if (flush) begin
            m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0;
        end else if (!stall) begin
            m_valid = ex_valid;
            m_rw = ex_valid & ex_reg_write;
            m_mr = ex_valid & ex_mem_read;
            m_mw = ex_valid & ex_mem_write;
            m_result = ex_result; m_sdata = ex_store_data; m_rd = ex_rd;
        end
        if (commit && ex_set_flags)
            m_nzcv = {ex_negative, ex_zero,
                      ex_logic_op ? 1'b0 : ex_carry_out,
                      ex_logic_op ? 1'b0 : ex_overflow};
        @(posedge clk); #1;
        chk({tag, ".valid"}, 64'(mem_valid), 64'(m_valid));
        chk({tag, ".rw"},    64'(mem_reg_write), 64'(m_rw));
        chk({tag, ".mrmw"},  64'({mem_mem_read, mem_mem_write}), 64'({m_mr, m_mw}));
        chk({tag, ".res"},   mem_result, m_result);
        chk({tag, ".sdata"}, mem_store_data, m_sdata);
        chk({tag, ".rd"},    64'(mem_rd), 64'(m_rd));
        chk({tag, ".nzcv"},  64'(nzcv()), 64'(m_nzcv));
    endtask

    task automatic flagset(input logic n, input logic z, input logic c, input logic v,
                           input logic lop);
        idle();
        ex_valid = 1; ex_set_flags = 1; ex_logic_op = lop;
        ex_negative = n; ex_zero = z; ex_carry_out = c; ex_overflow = v;
    endtask

    task automatic bcond(input logic [3:0] cc, input logic exp, input string tag);
        idle();
        ex_valid = 1; ex_is_bcond = 1; ex_cond = cc;
        #1 chk(tag, 64'(ex_branch_taken), 64'(exp));
    endtask

    initial begin
        logic [63:0] a, b, r;
        logic [64:0] sd;
        logic        exp_c, st;
        logic [3:0]  cc;

        idle();
        m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0;
        m_result = '0; m_sdata = '0; m_rd = '0; m_nzcv = 4'b0;
        reset_n = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.valid", 64'(mem_valid), 64'(0));
        chk("rst.res", mem_result, 64'(0));
        chk("rst.nzcv", 64'(nzcv()), 64'(0));
        @(negedge clk); reset_n = 1;

        // SUBS 5-5
        flagset(0, 1, 1, 0, 0);
        ex_reg_write = 1; ex_rd = 5'd3; ex_result = 64'd0; ex_store_data = 64'hdead;
        #1 chk("subs.br", 64'(ex_branch_taken), 64'(0));
        tick("subs");
        chk("subs.nzcv0110", 64'(nzcv()), 64'(4'b0110));
        bcond(4'b0000, 1, "beq"); tick("beq");
        bcond(4'b0001, 0, "bne"); tick("bne");

        // ANDS then ADD without flag write
        flagset(1, 0, 1, 1, 1); ex_result = 64'h8000_0000_0000_0000; tick("ands");
        chk("ands.nzcv1000", 64'(nzcv()), 64'(4'b1000));
        idle(); ex_valid = 1; ex_negative = 0; ex_zero = 1; ex_carry_out = 1;
        ex_overflow = 1; ex_reg_write = 1; ex_result = 64'h77; tick("add");
        chk("add.nzcv1000", 64'(nzcv()), 64'(4'b1000));

        bcond(4'b1011, 1, "blt.1000"); tick("blt1");
        flagset(1, 0, 0, 1, 0); tick("set1001");
        bcond(4'b1011, 0, "blt.1001"); tick("blt2");
        flagset(0, 0, 0, 0, 0); tick("set0000");
        bcond(4'b1100, 1, "bgt.0000"); tick("bgt");
        bcond(4'b1111, 1, "bal"); tick("bal");

        // CBZ under stall, then released
        idle(); ex_valid = 1; ex_is_cbz = 1; ex_zero = 1; stall = 1;
        ex_result = 64'hfeed_face_0bad_cafe; ex_rd = 5'd9; ex_reg_write = 1;
        #1 chk("cbz.stall.br", 64'(ex_branch_taken), 64'(0));
        tick("cbz.stall");
        stall = 0;
        #1 chk("cbz.go.br", 64'(ex_branch_taken), 64'(1));
        tick("cbz.go");
        idle(); ex_valid = 1; ex_is_cbnz = 1; ex_zero = 0;
        #1 chk("cbnz.br", 64'(ex_branch_taken), 64'(1));
        tick("cbnz");

        // stall + flush on ADDS
        flagset(1, 1, 1, 1, 0); ex_reg_write = 1; ex_is_bcond = 1; ex_cond = 4'b1110;
        stall = 1; flush = 1;
        #1 chk("sf.br", 64'(ex_branch_taken), 64'(0));
        tick("sf");
        chk("sf.valid0", 64'(mem_valid), 64'(0));

        // random SUBS a-b followed by B.cond judged by operand comparison
        for (int i = 0; i < 40; i++) begin
            a = {$urandom, $urandom};
            b = ($urandom_range(0, 3) == 0) ? a : {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) b[63] = ~a[63];
            r = a - b;
            sd = {a[63], a} - {b[63], b};
            flagset(r[63], r == 0, a >= b, sd[64] != sd[63], 0);
            ex_result = r; ex_store_data = b; ex_rd = 5'($urandom);
            ex_reg_write = 1; ex_mem_write = 1'($urandom);
            tick("rsubs");
            cc = 4'($urandom);
            case (cc)
                4'd0:  exp_c = (a == b);
                4'd1:  exp_c = (a != b);
                4'd2:  exp_c = (a >= b);
                4'd3:  exp_c = (a < b);
                4'd4:  exp_c = r[63];
                4'd5:  exp_c = !r[63];
                4'd6:  exp_c = (sd[64] != sd[63]);
                4'd7:  exp_c = (sd[64] == sd[63]);
                4'd8:  exp_c = (a > b);
                4'd9:  exp_c = (a <= b);
                4'd10: exp_c = ($signed(a) >= $signed(b));
                4'd11: exp_c = ($signed(a) < $signed(b));
                4'd12: exp_c = ($signed(a) > $signed(b));
                4'd13: exp_c = ($signed(a) <= $signed(b));
                default: exp_c = 1'b1;
            endcase
            st = ($urandom_range(0, 3) == 0);
            idle(); ex_valid = 1; ex_is_bcond = 1; ex_cond = cc; stall = st;
            ex_result = {$urandom, $urandom};
            #1 chk("rbcond", 64'(ex_branch_taken), 64'(exp_c & ~st));
            tick("rb");
        end

        // asynchronous reset in the middle of a cycle
        flagset(1, 1, 1, 1, 0); ex_result = 64'h1234; ex_reg_write = 1; tick("pre.rst");
        idle(); ex_valid = 1; ex_is_bcond = 1; ex_cond = 4'b1111;
        #2 reset_n = 0;
        #1;
        chk("arst.res", mem_result, 64'(0));
        chk("arst.valid", 64'(mem_valid), 64'(0));
        chk("arst.nzcv", 64'(nzcv()), 64'(0));
        chk("arst.br", 64'(ex_branch_taken), 64'(0));

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
